spi_master_controller: RTL

- Sequencing engine for the SPI byte transmitter. Generates SCLK from the system clock with a programmable divider, and drives per-slave active-low chip selects.
- Issues the load pulse and the per-bit shift pulses to the transmitter, and samples MISO into an 8-bit receive shift register.
- Sits between the SPI register interface (start/data/config) and the SPI pins.
- Supports all four CPOL/CPHA modes and MSB/LSB-first order.

---
 rtl/spi_master_controller.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_controller.sv
// -----------------------------------------------------------------------------
// spi_master_controller
//
// Sequencing engine for the SPI byte transmitter. It divides clk_i down to
// SCLK, drives the per-slave active-low chip selects, issues the load and
// per-bit shift pulses to the external transmitter, and assembles the MISO
// bits into a received byte.
//
// Ports:
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   start_i             start one byte transfer (accepted only when idle)
//   data_i, slave_i,
//   hold_cs_i, clk_div_i  per-transfer settings, sampled with start_i
//   cpol_i, cpha_i,
//   bit_order_i         SPI mode and bit order, static while busy_o is high
//   spi_miso_i          serial data from the slave
//   spi_sclk_o          SPI clock (idles at cpol_i)
//   spi_cs_n_o          active-low chip selects, one per slave
//   tx_transmit_o       one-cycle load pulse to the transmitter
//   tx_shift_o          one-cycle shift pulse to the transmitter
//   tx_data_o           byte presented to the transmitter
//   rx_data_o           received byte
//   rx_valid_o          one-cycle pulse when rx_data_o is updated
//   busy_o              transfer in progress
// -----------------------------------------------------------------------------
package spi_master_pkg;
    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_t;
endpackage

module spi_master_controller
    import spi_master_pkg::*;
#(
    parameter int  DIVIDER_WIDTH = 16,
    parameter int  SLAVES        = 4,
    localparam int SEL_W         = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [7:0]               data_i,
    input  logic [SEL_W-1:0]         slave_i,
    input  logic                     hold_cs_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_div_i,
    input  logic                     cpol_i,
    input  logic                     cpha_i,
    input  bit_order_t               bit_order_i,
    input  logic                     spi_miso_i,
    output logic                     spi_sclk_o,
    output logic [SLAVES-1:0]        spi_cs_n_o,
    output logic                     tx_transmit_o,
    output logic                     tx_shift_o,
    output logic [7:0]               tx_data_o,
    output logic [7:0]               rx_data_o,
    output logic                     rx_valid_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t                   state_r;
    logic [DIVIDER_WIDTH-1:0] div_r;
    logic [DIVIDER_WIDTH-1:0] cnt_r;
    logic [3:0]               edge_cnt_r;
    logic                     toggle_r;
    logic                     hold_cs_r;
    logic                     sample_pend_r;
    logic [7:0]               rx_shift_r;
    logic [SLAVES-1:0]        cs_n_r;
    logic                     tx_transmit_r;
    logic                     tx_shift_r;
    logic [7:0]               tx_data_r;
    logic [7:0]               rx_data_r;
    logic                     rx_valid_r;
    logic                     busy_r;

    logic [4:0]               edge_num_s;
    logic                     sample_s;
    logic                     shift_s;
    logic [7:0]               rx_shifted_s;
    logic [7:0]               rx_next_s;

    // Active-low one-hot select; an index beyond the last slave selects nothing.
    function automatic logic [SLAVES-1:0] cs_decode(input logic [SEL_W-1:0] idx);
        logic [SLAVES-1:0] cs_n;
        cs_n = {SLAVES{1'b1}};
        for (int i = 0; i < SLAVES; i++) begin
            if (idx == SEL_W'(i)) begin
                cs_n[i] = 1'b0;
            end else begin
                cs_n[i] = 1'b1;
            end
        end
        return cs_n;
    endfunction

    // Classify the SCLK edge about to be produced: sample or shift, per CPHA.
    always_comb begin
        edge_num_s = {1'b0, edge_cnt_r} + 5'd1;
        sample_s   = 1'b0;
        shift_s    = 1'b0;
        if (cpha_i == 1'b0) begin
            // Odd edges lead: sample there, shift on trailing edges 2..14.
            sample_s = edge_num_s[0];
            shift_s  = !edge_num_s[0] && (edge_num_s <= 5'd14);
        end else begin
            // Bit 0 comes from the load, so shifting starts at leading edge 3.
            sample_s = !edge_num_s[0];
            shift_s  = edge_num_s[0] && (edge_num_s >= 5'd3);
        end
    end

    // MISO is captured in the cycle the SCLK edge is visible on the pin.
    always_comb begin
        rx_shifted_s = 8'h00;
        if (bit_order_i == LSB_FIRST) begin
            rx_shifted_s = {spi_miso_i, rx_shift_r[7:1]};
        end else begin
            rx_shifted_s = {rx_shift_r[6:0], spi_miso_i};
        end
        if (sample_pend_r) begin
            rx_next_s = rx_shifted_s;
        end else begin
            rx_next_s = rx_shift_r;
        end
    end

    // Transfer sequencer: SETUP, 16 SCLK edges, HOLD, all paced by the divider.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r       <= IDLE;
            div_r         <= '0;
            cnt_r         <= '0;
            edge_cnt_r    <= 4'd0;
            toggle_r      <= 1'b0;
            hold_cs_r     <= 1'b0;
            sample_pend_r <= 1'b0;
            rx_shift_r    <= 8'h00;
            cs_n_r        <= {SLAVES{1'b1}};
            tx_transmit_r <= 1'b0;
            tx_shift_r    <= 1'b0;
            tx_data_r     <= 8'h00;
            rx_data_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            tx_transmit_r <= 1'b0;
            tx_shift_r    <= 1'b0;
            rx_valid_r    <= 1'b0;
            sample_pend_r <= 1'b0;
            rx_shift_r    <= rx_next_s;
            case (state_r)
                IDLE: begin
                    toggle_r <= 1'b0;
                    if (start_i) begin
                        div_r         <= clk_div_i;
                        hold_cs_r     <= hold_cs_i;
                        tx_data_r     <= data_i;
                        tx_transmit_r <= 1'b1;
                        busy_r        <= 1'b1;
                        cnt_r         <= '0;
                        edge_cnt_r    <= 4'd0;
                        rx_shift_r    <= 8'h00;
                        // Same slave keeps its select low; another slave swaps in one cycle.
                        cs_n_r        <= cs_decode(slave_i);
                        state_r       <= SETUP;
                    end else if (!hold_cs_r) begin
                        // Release lands on the first idle cycle, after the rx_valid pulse.
                        cs_n_r <= {SLAVES{1'b1}};
                    end else begin
                        cs_n_r <= cs_n_r;
                    end
                end
                SETUP: begin
                    if (cnt_r == div_r) begin
                        cnt_r   <= '0;
                        state_r <= TRANSFER;
                    end else begin
                        cnt_r <= cnt_r + DIVIDER_WIDTH'(1);
                    end
                end
                TRANSFER: begin
                    if (cnt_r == div_r) begin
                        cnt_r         <= '0;
                        toggle_r      <= ~toggle_r;
                        edge_cnt_r    <= edge_cnt_r + 4'd1;
                        sample_pend_r <= sample_s;
                        tx_shift_r    <= shift_s;
                        if (edge_cnt_r == 4'd15) begin
                            state_r <= HOLD;
                        end else begin
                            state_r <= TRANSFER;
                        end
                    end else begin
                        cnt_r <= cnt_r + DIVIDER_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (cnt_r == div_r) begin
                        cnt_r      <= '0;
                        rx_data_r  <= rx_next_s;
                        rx_valid_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + DIVIDER_WIDTH'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    toggle_r <= 1'b0;
                    busy_r   <= 1'b0;
                    cs_n_r   <= {SLAVES{1'b1}};
                end
            endcase
        end
    end

    assign spi_sclk_o    = cpol_i ^ toggle_r;
    assign spi_cs_n_o    = cs_n_r;
    assign tx_transmit_o = tx_transmit_r;
    assign tx_shift_o    = tx_shift_r;
    assign tx_data_o     = tx_data_r;
    assign rx_data_o     = rx_data_r;
    assign rx_valid_o    = rx_valid_r;
    assign busy_o        = busy_r;

endmodule
